// File: rtl/centipede_rom_loader_pkg.sv
// Shared constants and types for the Centipede ROM loader: region sizes,
// write-port region encodings and the loader FSM state.
package centipede_rom_loader_pkg;

  localparam int unsigned PROG_BYTES_DEF = 8192;
  localparam int unsigned GFX_BYTES_DEF  = 4096;
  localparam int unsigned MEM_ADDR_W     = 13;

  localparam logic SEL_PROG = 1'b0;
  localparam logic SEL_GFX  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/centipede_rom_loader_if.sv
// Bus bundles around the loader: the ioctl byte-download stream (driven by the
// download source) and the req/ack memory write port (driven by the loader).
interface centipede_ioctl_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait
  );
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait
  );
endinterface

interface centipede_mem_if;
  logic        mem_req;
  logic        mem_sel;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;

  modport master (
    output mem_req, mem_sel, mem_addr, mem_data,
    input  mem_ack
  );
  modport slave (
    input  mem_req, mem_sel, mem_addr, mem_data,
    output mem_ack
  );
endinterface

// File: rtl/centipede_rom_loader.sv
// Streams the ioctl ROM download into program/graphics ROM through a req/ack
// write port, holding the game core in reset until the image is in place.
module centipede_rom_loader
  import centipede_rom_loader_pkg::*;
#(
  parameter int unsigned PROG_BYTES = PROG_BYTES_DEF,
  parameter int unsigned GFX_BYTES  = GFX_BYTES_DEF,
  parameter logic [7:0]  ROM_INDEX  = 8'h00,
  parameter int unsigned RESET_HOLD = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  centipede_ioctl_if.slave  ioctl,
  centipede_mem_if.master   mem,
  output logic              core_reset,
  output logic              load_done,
  output logic [15:0]       byte_count,
  output logic [7:0]        checksum,
  output logic              overrun
);

  localparam int unsigned TOTAL_BYTES = PROG_BYTES + GFX_BYTES;
  localparam int unsigned HOLD_W      = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  state_t                  state;
  logic                    dl_q;
  logic                    wait_q;
  logic                    req_q;
  logic                    sel_q;
  logic [MEM_ADDR_W-1:0]   addr_q;
  logic [7:0]              data_q;
  logic [HOLD_W-1:0]       hold_cnt;

  logic start_load;
  logic in_range;
  logic in_gfx;

  // A new load starts only on the rising edge of the download window.
  assign start_load = ioctl.ioctl_download && !dl_q && (ioctl.ioctl_index == ROM_INDEX);
  assign in_range   = ioctl.ioctl_addr < 25'(TOTAL_BYTES);
  assign in_gfx     = ioctl.ioctl_addr >= 25'(PROG_BYTES);

  assign ioctl.ioctl_wait = wait_q;
  assign mem.mem_req      = req_q;
  assign mem.mem_sel      = sel_q;
  assign mem.mem_addr     = addr_q;
  assign mem.mem_data     = data_q;

  // NOTE: every register here sits on the async reset so an external reset
  // mid-write drops mem_req at once; non-blocking assignments keep the
  // read-old/write-new semantics the FSM relies on.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      dl_q       <= 1'b0;
      wait_q     <= 1'b0;
      req_q      <= 1'b0;
      sel_q      <= SEL_PROG;
      addr_q     <= '0;
      data_q     <= '0;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      byte_count <= '0;
      checksum   <= '0;
      overrun    <= 1'b0;
    end else begin
      dl_q <= ioctl.ioctl_download;

      if (ioctl.ioctl_wr && wait_q) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_HOLD: begin
          if (start_load) begin
            state      <= ST_LOAD;
            core_reset <= 1'b1;
            byte_count <= '0;
            checksum   <= '0;
            load_done  <= 1'b0;
            overrun    <= 1'b0;
          end else if (state == ST_HOLD) begin
            if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
              state      <= ST_IDLE;
              core_reset <= 1'b0;
              load_done  <= (byte_count == 16'(TOTAL_BYTES));
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (!ioctl.ioctl_download) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end else if (ioctl.ioctl_wr && in_range) begin
            state  <= ST_WRITE;
            req_q  <= 1'b1;
            wait_q <= 1'b1;
            sel_q  <= in_gfx ? SEL_GFX : SEL_PROG;
            addr_q <= in_gfx ? MEM_ADDR_W'(ioctl.ioctl_addr - 25'(PROG_BYTES))
                             : MEM_ADDR_W'(ioctl.ioctl_addr);
            data_q <= ioctl.ioctl_dout;
          end
        end

        ST_WRITE: begin
          if (mem.mem_ack) begin
            req_q    <= 1'b0;
            wait_q   <= 1'b0;
            checksum <= checksum + data_q;
            if (byte_count != 16'hFFFF) begin
              byte_count <= byte_count + 16'd1;
            end
            // A window that closed during the write goes straight to HOLD.
            state    <= ioctl.ioctl_download ? ST_LOAD : ST_HOLD;
            hold_cnt <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centipede_rom_loader.sv
// Scoreboard bench for centipede_rom_loader: a source model drives ioctl bytes,
// a memory model acks writes and checks them against the expected queue.
module tb_centipede_rom_loader;

  localparam int PROG  = 8192;
  localparam int GFX   = 4096;
  localparam int TOTAL = PROG + GFX;
  localparam int HOLD  = 16;

  typedef struct {
    logic        sel;
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        core_reset;
  logic        load_done;
  logic [15:0] byte_count;
  logic [7:0]  checksum;
  logic        overrun;

  centipede_ioctl_if ioctl_bus ();
  centipede_mem_if   mem_bus ();

  centipede_rom_loader #(
    .PROG_BYTES (PROG),
    .GFX_BYTES  (GFX),
    .ROM_INDEX  (8'h00),
    .RESET_HOLD (HOLD)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ioctl      (ioctl_bus),
    .mem        (mem_bus),
    .core_reset (core_reset),
    .load_done  (load_done),
    .byte_count (byte_count),
    .checksum   (checksum),
    .overrun    (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int         checks = 0;
  int         failures = 0;
  wr_t        sb[$];
  int         ack_latency = 1;
  int         writes_done = 0;
  int         byte_model = 0;
  logic [7:0] sum_model = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: acks ack_latency cycles after req is first seen.
  initial begin : mem_model
    int          wcnt;
    logic [20:0] cap;
    wr_t         e;
    wcnt = 0;
    cap  = '0;
    mem_bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (mem_bus.mem_ack) begin
        mem_bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_bus.mem_req) begin
        if (wcnt == 0) cap = {mem_bus.mem_addr, mem_bus.mem_data};
        if (wcnt == ack_latency) begin
          mem_bus.mem_ack = 1'b1;
          writes_done++;
          check("wr_stable", {mem_bus.mem_addr, mem_bus.mem_data}, cap);
          check("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("wr_word", {mem_bus.mem_sel, mem_bus.mem_addr, mem_bus.mem_data},
                  {e.sel, e.addr, e.data});
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_wr,
                           input bit inject, output int waits);
    wr_t e;
    ioctl_bus.ioctl_addr = a;
    ioctl_bus.ioctl_dout = d;
    ioctl_bus.ioctl_wr   = 1'b1;
    if (expect_wr) begin
      e.sel  = (a >= 25'(PROG));
      e.addr = e.sel ? 13'(a - 25'(PROG)) : a[12:0];
      e.data = d;
      sb.push_back(e);
      byte_model++;
      sum_model = sum_model + d;
    end
    @(negedge clk_sys);
    ioctl_bus.ioctl_wr = 1'b0;
    waits = 0;
    while (ioctl_bus.ioctl_wait && waits < 64) begin
      waits++;
      ioctl_bus.ioctl_wr = inject && (waits == 2);
      if (ioctl_bus.ioctl_wr) begin
        ioctl_bus.ioctl_dout = 8'hEE;
        ioctl_bus.ioctl_addr = 25'd5;
      end
      @(negedge clk_sys);
    end
    ioctl_bus.ioctl_wr = 1'b0;
    if (waits >= 64) check("wait_timeout", waits, 0);
  endtask

  task automatic start_download(input logic [7:0] idx);
    ioctl_bus.ioctl_index    = idx;
    ioctl_bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_download(output int held);
    ioctl_bus.ioctl_download = 1'b0;
    held = 0;
    @(negedge clk_sys);
    while (core_reset && held < 200) begin
      held++;
      @(negedge clk_sys);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_wait"},   ioctl_bus.ioctl_wait, 0);
    check({pfx, "_req"},    mem_bus.mem_req, 0);
    check({pfx, "_sel"},    mem_bus.mem_sel, 0);
    check({pfx, "_addr"},   mem_bus.mem_addr, 0);
    check({pfx, "_data"},   mem_bus.mem_data, 0);
    check({pfx, "_corers"}, core_reset, 1);
    check({pfx, "_done"},   load_done, 0);
    check({pfx, "_count"},  byte_count, 0);
    check({pfx, "_csum"},   checksum, 0);
    check({pfx, "_ovr"},    overrun, 0);
  endtask

  initial begin : watchdog
    #5ms;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w;
    int held;
    logic [24:0] a;

    reset_n = 1'b0;
    ioctl_bus.ioctl_download = 1'b0;
    ioctl_bus.ioctl_wr       = 1'b0;
    ioctl_bus.ioctl_addr     = '0;
    ioctl_bus.ioctl_dout     = '0;
    ioctl_bus.ioctl_index    = '0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check_reset_outputs("rst");

    // Full image, 1-cycle ack latency, then two out-of-range bytes.
    ack_latency = 1;
    start_download(8'h00);
    check("a_corers_load", core_reset, 1);
    for (int i = 0; i < TOTAL; i++) begin
      send_byte(25'(i), 8'($urandom), 1'b1, 1'b0, w);
      if (i == 0) check("a_wait_lat1", w, 2);
    end
    send_byte(25'd12288, 8'h11, 1'b0, 1'b0, w);
    check("a_oor_12288_wait", w, 0);
    send_byte(25'd20000, 8'h22, 1'b0, 1'b0, w);
    check("a_oor_20000_wait", w, 0);
    check("a_count_pre", byte_count, TOTAL);
    end_download(held);
    check("a_hold_cycles", held, HOLD);
    check("a_done",   load_done, 1);
    check("a_count",  byte_count, byte_model);
    check("a_csum",   checksum, sum_model);
    check("a_ovr",    overrun, 0);
    check("a_corers", core_reset, 0);
    check("a_writes", writes_done, TOTAL);
    check("a_sb_left", sb.size(), 0);

    // Foreign index: loader must stay idle and keep everything as it was.
    start_download(8'h01);
    for (int i = 0; i < 3; i++) begin
      send_byte(25'(i), 8'(i + 1), 1'b0, 1'b0, w);
      check("c_no_wait", w, 0);
    end
    ioctl_bus.ioctl_download = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("c_writes", writes_done, TOTAL);
    check("c_corers", core_reset, 0);
    check("c_count",  byte_count, TOTAL);
    check("c_csum",   checksum, sum_model);
    check("c_done",   load_done, 1);

    // Short download, 5-cycle ack latency, with one overrun strobe.
    ack_latency = 5;
    byte_model  = 0;
    sum_model   = 8'h00;
    start_download(8'h00);
    check("b_done_clr",  load_done, 0);
    check("b_count_clr", byte_count, 0);
    check("b_corers",    core_reset, 1);
    for (int i = 0; i < 100; i++) begin
      a = 25'((i * 123) % TOTAL);
      send_byte(a, 8'($urandom), 1'b1, (i == 10), w);
      if (i == 0) check("b_wait_lat5", w, 6);
    end
    check("b_ovr_set", overrun, 1);
    end_download(held);
    check("b_hold_cycles", held, HOLD);
    check("b_done",  load_done, 0);
    check("b_count", byte_count, 100);
    check("b_csum",  checksum, sum_model);
    check("b_ovr",   overrun, 1);
    check("b_sb_left", sb.size(), 0);

    // Reset pulse in the middle of a write.
    start_download(8'h00);
    check("d_corers", core_reset, 1);
    ioctl_bus.ioctl_addr = 25'd5;
    ioctl_bus.ioctl_dout = 8'h5A;
    ioctl_bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_bus.ioctl_wr = 1'b0;
    check("d_req_up", mem_bus.mem_req, 1);
    check("d_data_up", mem_bus.mem_data, 8'h5A);
    @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    ioctl_bus.ioctl_download = 1'b0;
    #1;
    check_reset_outputs("d_async");
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    check("d_writes", writes_done, TOTAL + 100);
    check("d_req_idle", mem_bus.mem_req, 0);
    check("d_corers_idle", core_reset, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
